// File: rtl/program_loader.sv
// Byte-stream program loader: reads a length-prefixed, XOR-checksummed word stream and
// writes it into program memory, holding the downstream CPU in reset until a good load.
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_IDLE   | after reset, waiting for start
// S_LEN_HI | expecting the word-count high byte
// S_LEN_LO | expecting the word-count low byte
// S_DATA   | assembling a 32-bit word, MSB first
// S_WRITE  | one-cycle memory write of the assembled word
// S_CHECK  | expecting the checksum byte
// S_DONE   | load good, CPU released (sticky until next start)
// S_ERROR  | checksum mismatch or timeout (sticky until next start)
module program_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_data_in,
   output logic        mem_we,
   output logic        cpu_reset,
   output logic        load_done,
   output logic        load_error,
   output logic [15:0] words_loaded
);

   localparam int IW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t         state_q, state_d;
   logic [15:0]    len_q, len_d;
   logic [31:0]    word_q, word_d;
   logic [1:0]     byte_cnt_q, byte_cnt_d;
   logic [7:0]     chk_q, chk_d;
   logic [15:0]    words_q, words_d;
   logic [IW-1:0]  idle_q, idle_d;
   logic           in_ready_q, mem_we_q, cpu_reset_q, load_done_q, load_error_q;
   logic [15:0]    mem_addr_q;
   logic [31:0]    mem_data_q;

   logic           xfer, byte_state, timeout_hit;
   logic [IW-1:0]  idle_inc;

   assign xfer        = in_valid & in_ready_q;
   assign byte_state  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
   assign idle_inc    = idle_q + 1'b1;
   assign timeout_hit = (idle_inc == IW'(TIMEOUT));

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_d     = word_q;
      byte_cnt_d = byte_cnt_q;
      chk_d      = chk_q;
      words_d    = words_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d    = S_LEN_HI;
               words_d    = 16'd0;
               chk_d      = 8'd0;
               byte_cnt_d = 2'd0;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d[15:8] = in_data;
               state_d     = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = in_data;
               state_d    = ({len_q[15:8], in_data} == 16'd0) ? S_CHECK : S_DATA;
            end
         end
         S_DATA: begin
            if (xfer) begin
               word_d     = {word_q[23:0], in_data};
               chk_d      = chk_q ^ in_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            words_d = words_q + 16'd1;
            state_d = ((words_q + 16'd1) == len_q) ? S_CHECK : S_DATA;
         end
         S_CHECK: begin
            if (xfer) state_d = (in_data == chk_q) ? S_DONE : S_ERROR;
         end
         default: state_d = S_IDLE;
      endcase
      if (byte_state && !xfer && timeout_hit) state_d = S_ERROR;
   end

   // Idle counter restarts on any transfer and on every state change.
   always_comb begin
      idle_d = '0;
      if (byte_state && !xfer && (state_d == state_q)) idle_d = idle_inc;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         len_q        <= 16'd0;
         word_q       <= 32'd0;
         byte_cnt_q   <= 2'd0;
         chk_q        <= 8'd0;
         words_q      <= 16'd0;
         idle_q       <= '0;
         in_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 16'd0;
         mem_data_q   <= 32'd0;
         cpu_reset_q  <= 1'b1;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_q       <= word_d;
         byte_cnt_q   <= byte_cnt_d;
         chk_q        <= chk_d;
         words_q      <= words_d;
         idle_q       <= idle_d;
         in_ready_q   <= (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                         (state_d == S_DATA)   || (state_d == S_CHECK);
         mem_we_q     <= (state_d == S_WRITE);
         cpu_reset_q  <= (state_d != S_DONE);
         load_done_q  <= (state_d == S_DONE);
         load_error_q <= (state_d == S_ERROR);
         // words_q still holds the pre-increment count while entering WRITE.
         if (state_d == S_WRITE) begin
            mem_addr_q <= BASE_ADDR + words_q;
            mem_data_q <= word_d;
         end
      end
   end

   assign in_ready     = in_ready_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data_in  = mem_data_q;
   assign cpu_reset    = cpu_reset_q;
   assign load_done    = load_done_q;
   assign load_error   = load_error_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (base 0000/timeout 1024 and base FFFF/timeout 16)
// share one byte stream; observed memory writes and flags are compared with a stream model.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset, start, in_valid;
   logic [7:0]  in_data;

   logic        r0, we0, cr0, dn0, er0;
   logic [15:0] a0, wl0;
   logic [31:0] d0;
   logic        r1, we1, cr1, dn1, er1;
   logic [15:0] a1, wl1;
   logic [31:0] d1;

   int checks   = 0;
   int failures = 0;

   logic [47:0] wq0[$];
   logic [47:0] wq1[$];

   program_loader u0 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(r0), .mem_addr(a0), .mem_data_in(d0), .mem_we(we0), .cpu_reset(cr0),
      .load_done(dn0), .load_error(er0), .words_loaded(wl0)
   );

   program_loader #(.BASE_ADDR(16'hFFFF), .TIMEOUT(16)) u1 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(r1), .mem_addr(a1), .mem_data_in(d1), .mem_we(we1), .cpu_reset(cr1),
      .load_done(dn1), .load_error(er1), .words_loaded(wl1)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we0) wq0.push_back({a0, d0});
      if (we1) wq1.push_back({a1, d1});
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_u0"}, {r0, a0, d0, we0, cr0, dn0, er0, wl0},
                {1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
      check_val({tag, "_u1"}, {r1, a1, d1, we1, cr1, dn1, er1, wl1},
                {1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("start_u0", {r0, cr0, dn0, er0, wl0}, {1'b1, 1'b1, 1'b0, 1'b0, 16'h0});
      check_val("start_u1", {r1, cr1, dn1, er1, wl1}, {1'b1, 1'b1, 1'b0, 1'b0, 16'h0});
   endtask

   task automatic send_byte(input logic [7:0] b, input bit with_start);
      int budget;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (with_start) start = 1'b1;
      budget = 50;
      while (!(r0 && r1) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check_val("ready_wait", 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   // Model: words land at base+i (16-bit wrap); done iff checksum byte == XOR of payload.
   task automatic run_session(input string tag, input logic [31:0] pay[$], input logic [7:0] flip,
                              input int start_at);
      logic [7:0]  bytes[$];
      logic [7:0]  x;
      logic [15:0] n, base, wl;
      logic        dn, er, cr, we;
      logic [47:0] q[$];
      bit          good;
      n = 16'(pay.size());
      x = 8'h00;
      bytes.push_back(n[15:8]);
      bytes.push_back(n[7:0]);
      foreach (pay[i]) begin
         for (int k = 3; k >= 0; k--) begin
            bytes.push_back(pay[i][k*8 +: 8]);
            x ^= pay[i][k*8 +: 8];
         end
      end
      bytes.push_back(x ^ flip);
      good = (flip == 8'h00);
      wq0.delete();
      wq1.delete();
      do_start();
      foreach (bytes[i]) send_byte(bytes[i], i == start_at);
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         base = (u == 1) ? 16'hFFFF : 16'h0000;
         q    = (u == 1) ? wq1 : wq0;
         dn   = (u == 1) ? dn1 : dn0;
         er   = (u == 1) ? er1 : er0;
         cr   = (u == 1) ? cr1 : cr0;
         we   = (u == 1) ? we1 : we0;
         wl   = (u == 1) ? wl1 : wl0;
         check_val($sformatf("%s_u%0d_nwr", tag, u), q.size(), n);
         for (int i = 0; i < q.size() && i < int'(n); i++)
            check_val($sformatf("%s_u%0d_wr%0d", tag, u, i), q[i], {16'(base + 16'(i)), pay[i]});
         check_val($sformatf("%s_u%0d_flags", tag, u), {dn, er, cr, we},
                   {good, !good, !good, 1'b0});
         check_val($sformatf("%s_u%0d_words", tag, u), wl, n);
      end
   endtask

   initial begin
      logic [31:0] pay[$];
      logic [7:0]  flip;
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b1;
      @(negedge clk);

      pay = '{32'h11223344, 32'h55667788};
      run_session("good2", pay, 8'h00, 6);
      run_session("badchk", pay, 8'h88, 3);
      pay.delete();
      run_session("empty", pay, 8'h00, -1);

      // Timeout: 00 01 AA then silence; only the TIMEOUT=16 instance may give up.
      wq0.delete();
      wq1.delete();
      do_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'hAA, 1'b0);
      repeat (15) @(negedge clk);
      check_val("tmo_early", er1, 1'b0);
      @(negedge clk);
      check_val("tmo_err", {er1, cr1, dn1, r1}, {1'b1, 1'b1, 1'b0, 1'b0});
      check_val("tmo_long", {er0, r0}, {1'b0, 1'b1});
      check_val("tmo_nowr", wq0.size() + wq1.size(), 0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Mid-session reset after the 3rd payload byte, with an ignored start pulse.
      wq0.delete();
      wq1.delete();
      do_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'hDE, 1'b1);
      send_byte(8'hAD, 1'b0);
      send_byte(8'hBE, 1'b0);
      check_val("mid_ready", {r0, r1, wl0, wl1}, {1'b1, 1'b1, 16'h0, 16'h0});
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_reset_vals("midrst");
      check_val("midrst_nowr", wq0.size() + wq1.size(), 0);
      repeat (3) @(negedge clk);
      check_val("midrst_idle", {r0, r1, we0, we1}, 4'b0000);

      for (int it = 0; it < 6; it++) begin
         pay.delete();
         repeat ($urandom_range(0, 4)) pay.push_back($urandom);
         flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         run_session($sformatf("rnd%0d", it), pay, flip,
                     int'($urandom_range(0, 4 * pay.size() + 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000, is the memory word address receiving the first loaded word.
REQ-002 Parameter TIMEOUT, default 1024, is the maximum idle cycles between bytes while loading before an error is raised.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled only on the clk rising edge.
REQ-005 Port: start  input  1  single-cycle request to begin a load session.
REQ-006 Port: in_valid  input  1  byte-stream valid.
REQ-007 Port: in_data  input  8  byte-stream data.
REQ-008 Port: in_ready  output  1  loader accepts a byte this cycle.
REQ-009 Port: mem_addr  output  16  program-memory word address.
REQ-010 Port: mem_data_in  output  32  program-memory write data.
REQ-011 Port: mem_we  output  1  program-memory write strobe, one cycle per word.
REQ-012 Port: cpu_reset  output  1  active-high hold for the downstream processor.
REQ-013 Port: load_done  output  1  session completed with a good checksum; sticky.
REQ-014 Port: load_error  output  1  session aborted on checksum mismatch or timeout; sticky.
REQ-015 Port: words_loaded  output  16  count of words written this session.

Function
REQ-016 A byte transfer shall occur on any cycle where in_valid and in_ready are both 1; no other cycle consumes a byte.
REQ-017 The stream format shall be: LEN_HI, LEN_LO (word count N, big-endian), then 4*N payload bytes (each word MSB first), then one checksum byte.
REQ-018 The FSM states shall be IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE and ERROR.
REQ-019 IDLE: in_ready=0; on start=1 the FSM shall clear words_loaded, the checksum, load_done and load_error, and move to LEN_HI.
REQ-020 LEN_HI and LEN_LO shall each accept one byte. After LEN_LO the FSM moves to DATA if N>0, else to CHECK.
REQ-021 DATA shall shift accepted bytes into a 32-bit word register MSB first and XOR each byte into the 8-bit checksum. After the 4th byte it moves to WRITE.
REQ-022 WRITE (exactly one cycle, in_ready=0): mem_we=1, mem_addr=BASE_ADDR+words_loaded (mod 2^16, wraps FFFF->0000), mem_data_in=assembled word.
REQ-023 On leaving WRITE, words_loaded increments. The FSM returns to DATA, or goes to CHECK when words_loaded reaches N.
REQ-024 CHECK shall accept one byte. It moves to DONE if that byte equals the running XOR, else to ERROR.
REQ-025 DONE: load_done=1, cpu_reset=0, in_ready=0. A new start re-enters LEN_HI and re-asserts cpu_reset.
REQ-026 ERROR: load_error=1, cpu_reset=1, in_ready=0. A new start re-enters LEN_HI.
REQ-027 cpu_reset shall be 1 in every state except DONE.
REQ-028 A start pulse in any state other than IDLE, DONE or ERROR shall be ignored.
REQ-029 In LEN_HI, LEN_LO, DATA and CHECK, an idle counter shall count cycles without a byte transfer and clear on every transfer. Reaching TIMEOUT moves the FSM to ERROR.
REQ-030 The idle counter shall be cleared on every state entry.
REQ-031 mem_we shall be 0 outside WRITE. mem_addr and mem_data_in shall hold their last values when mem_we=0.
REQ-032 in_ready shall be a registered function of state only: 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 elsewhere.

Reset
REQ-033 While reset=0 at a clk edge: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_data_in=0, cpu_reset=1, load_done=0, load_error=0, words_loaded=0, checksum=0, idle counter=0.
REQ-034 Reset asserted mid-session shall abandon the session with no further memory writes. Partially written words are not cleared.

Verification
REQ-035 BASE_ADDR=0; start, then bytes 00 02 | 11 22 33 44 | 55 66 77 88 | checksum 88 -> writes (0000, 11223344), (0001, 55667788); load_done=1; cpu_reset=0; words_loaded=2.
REQ-036 Same stream with checksum 00 -> both words written, load_error=1, cpu_reset stays 1, load_done=0.
REQ-037 start, then 00 00 00 -> no mem_we pulse, load_done=1, words_loaded=0.
REQ-038 TIMEOUT=16; start, 00 01 AA, then in_valid=0 for 16 cycles -> load_error=1, no mem_we.
REQ-039 BASE_ADDR=FFFF; 2-word load -> writes land at FFFF then 0000.
REQ-040 During a session, in_valid held high with random stalls and start pulsed mid-stream; then reset=0 for 1 cycle after the 3rd payload byte -> start ignored, no write issued, all outputs at REQ-033 values next cycle.
